// File: rtl/rom_1_bit_pkg.sv
// Shared constants and self-check state type for the 1-bit ROM.
// Holds the default geometry, contents and expected parity, plus the
// IDLE/SWEEP/DONE state encoding used by the built-in self-check.
package rom_1_bit_pkg;

  localparam int unsigned DEFAULT_ADDR_W       = 2;
  localparam logic [3:0]  DEFAULT_INIT         = 4'b1010;
  localparam logic        DEFAULT_CHECK_PARITY = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } bist_state_e;

endpackage : rom_1_bit_pkg

// File: rtl/rom_1_bit_bist.sv
// Built-in self-check for the 1-bit ROM: after reset it sweeps every entry
// once through its own combinational read port, XOR-accumulates the bits
// and compares the result against the expected parity.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   rd_addr_c  - combinational read address into the ROM contents
//   rd_data_c  - combinational read data for rd_addr_c
//   bist_done  - sweep finished, held until reset
//   bist_fail  - parity mismatch, valid when bist_done=1
module rom_1_bit_bist
  import rom_1_bit_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter logic        CHECK_PARITY = DEFAULT_CHECK_PARITY
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr_c,
  input  logic              rd_data_c,
  output logic              bist_done,
  output logic              bist_fail
);

  // One extra index bit so the last-entry test never depends on wrap-around.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2 ** ADDR_W) - 1);

  bist_state_e     state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic            acc_q, acc_d;
  logic            done_d, fail_d;

  assign rd_addr_c = idx_q[ADDR_W-1:0];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      bist_done <= done_d;
      bist_fail <= fail_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    done_d  = bist_done;
    fail_d  = bist_fail;
    case (state_q)
      IDLE: begin
        state_d = SWEEP;
        idx_d   = '0;
        acc_d   = 1'b0;
      end
      SWEEP: begin
        acc_d = acc_q ^ rd_data_c;
        idx_d = idx_q + (ADDR_W+1)'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          fail_d  = ((acc_q ^ rd_data_c) != CHECK_PARITY);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : rom_1_bit_bist

// File: rtl/rom_1_bit.sv
// 1-bit wide constant ROM with a built-in parity self-check.
// Optional feature macro: ROM_1_BIT_REG_OUT_EN -- when defined, data is
// registered (1-cycle latency, reset to 0); otherwise data is combinational.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   addr       - read address (ADDR_W bits)
//   data       - ROM entry at addr
//   bist_done  - self-check sweep finished, held until reset
//   bist_fail  - self-check parity mismatch, valid when bist_done=1
module rom_1_bit
  import rom_1_bit_pkg::*;
#(
  parameter int unsigned             ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [2**ADDR_W-1:0]    INIT         = DEFAULT_INIT,
  parameter logic                    CHECK_PARITY = DEFAULT_CHECK_PARITY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic              data,
  output logic              bist_done,
  output logic              bist_fail
);

  logic [ADDR_W-1:0] bist_addr_c;
  logic              bist_data_c;

  // Second, independent read port so the self-check never touches the read path.
  assign bist_data_c = INIT[bist_addr_c];

`ifdef ROM_1_BIT_REG_OUT_EN
  // Registered read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 1'b0;
    end else begin
      data <= INIT[addr];
    end
  end
`else
  // Combinational read path.
  assign data = INIT[addr];
`endif

  rom_1_bit_bist #(
    .ADDR_W       (ADDR_W),
    .CHECK_PARITY (CHECK_PARITY)
  ) u_bist (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_c (bist_addr_c),
    .rd_data_c (bist_data_c),
    .bist_done (bist_done),
    .bist_fail (bist_fail)
  );

endmodule : rom_1_bit

// File: tb/tb_rom_1_bit.sv
// Self-checking bench for rom_1_bit: randomized reads and reset pulses
// compared against a behavioural model of the ROM and its self-check.
module tb_rom_1_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] addr = 2'd0;
  logic       data, bist_done, bist_fail;
  logic       data_p, bist_done_p, bist_fail_p;

  always #5 clk = ~clk;

  rom_1_bit #(.ADDR_W(2), .INIT(4'b1010), .CHECK_PARITY(1'b0)) u_dut (
    .clk(clk), .rst(rst), .addr(addr),
    .data(data), .bist_done(bist_done), .bist_fail(bist_fail)
  );

  rom_1_bit #(.ADDR_W(2), .INIT(4'b1010), .CHECK_PARITY(1'b1)) u_dut_par (
    .clk(clk), .rst(rst), .addr(addr),
    .data(data_p), .bist_done(bist_done_p), .bist_fail(bist_fail_p)
  );

  // Reference model
  logic [3:0] rom = 4'b1010;
  int         depth = 4;
  int         since_rel = 0;   // rising edges with rst=0 since last reset edge
  logic       exp_reg = 1'b0;  // registered read path value
  logic       rom_par;

  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) begin
    if (rst) begin
      since_rel = 0;
      exp_reg   = 1'b0;
    end else begin
      since_rel = since_rel + 1;
      exp_reg   = rom[addr];
    end
  end

  function automatic logic exp_data();
`ifdef ROM_1_BIT_REG_OUT_EN
    return exp_reg;
`else
    return rom[addr];
`endif
  endfunction

  // One cycle to leave IDLE, then one cycle per entry.
  function automatic logic exp_done();
    return (since_rel >= depth + 1);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    check("data",      data,        exp_data());
    check("data_p",    data_p,      exp_data());
    check("done",      bist_done,   exp_done());
    check("fail",      bist_fail,   exp_done() && (rom_par != 1'b0));
    check("done_p",    bist_done_p, exp_done());
    check("fail_p",    bist_fail_p, exp_done() && (rom_par != 1'b1));
  endtask

  task automatic step(input logic r, input logic [1:0] a);
    @(posedge clk);
    #1;
    rst  = r;
    addr = a;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rom_par = ^rom;

    // Reset phase.
    repeat (3) step(1'b1, 2'd0);

    // Address change with no clock edge between.
    #1 addr = 2'd0;
    #1 check("noedge_a0", data, exp_data());
    addr = 2'd1;
    #1 check("noedge_a1", data, exp_data());

    // Release reset and sweep all addresses in order.
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i));
    repeat (4) step(1'b0, 2'($urandom_range(0, 3)));

    // Reset mid-sweep, then release.
    repeat (2) step(1'b1, 2'd2);
    repeat (2) step(1'b0, 2'd3);
    step(1'b1, 2'd1);
    repeat (7) step(1'b0, 2'($urandom_range(0, 3)));

    // Random reads with occasional reset pulses.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rom_1_bit
